btn_pulse_shaper: RTL and testbench

Conditions one raw, active-low push-button input into a clean single-cycle pulse: a two-flop synchronizer, then a debounce state machine requiring a stable level for a programmable number of cycles on both press and release. It sits directly upstream of the 4-bit event counter: `pulse_out` drives that counter's `sig_in`, so each physical press advances the count by exactly one regardless of hold time or contact bounce.

---
 rtl/btn_pulse_shaper.sv | 111 +++++++++++
 tb/tb_btn_pulse_shaper.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/btn_pulse_shaper.sv
// rtl/btn_pulse_shaper.sv - synchronize, debounce and pulse-shape an active-low push button
module btn_pulse_shaper #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn_n,
    output logic pulse_out,
    output logic pressed
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_DB   = 3'd1,
        PULSE      = 3'd2,
        HELD       = 3'd3,
        RELEASE_DB = 3'd4
    } state_t;

    // Last debounce count before a level is accepted; the counter never goes past it.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             s1;
    logic             s2;
    logic             btn_s;

    assign btn_s = s2;

    // Two-flop synchronizer; inverts so that 1 means pressed, resets to released.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= ~btn_n;
            s2 <= s1;
        end
    end

    // State, debounce counter and registered outputs decoded from the next state.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE;
            cnt       <= '0;
            pulse_out <= 1'b0;
            pressed   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pulse_out <= (state_nxt == PULSE);
            pressed   <= (state_nxt == PULSE) || (state_nxt == HELD) ||
                         (state_nxt == RELEASE_DB);
        end
    end

    // Debounce transitions: a level must persist DB_CYCLES samples inside a DB state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_nxt = PRESS_DB;
                    cnt_nxt   = '0;
                end
            end
            PRESS_DB: begin
                if (!btn_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = PULSE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PULSE: begin
                state_nxt = HELD;
                cnt_nxt   = '0;
            end
            HELD: begin
                if (!btn_s) begin
                    state_nxt = RELEASE_DB;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_DB: begin
                if (btn_s) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_btn_pulse_shaper.sv
// tb/tb_btn_pulse_shaper.sv - directed self-checking bench for btn_pulse_shaper
module tb_btn_pulse_shaper;

    logic CLK;
    logic RST;
    logic btn_n;
    logic pulse_out;
    logic pressed;
    logic pulse_out1;
    logic pressed1;

    int n_assert = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;
    logic [3:0] ev_cnt = 4'd0;

    btn_pulse_shaper #(.DB_CYCLES(4), .CNT_W(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .btn_n     (btn_n),
        .pulse_out (pulse_out),
        .pressed   (pressed)
    );

    btn_pulse_shaper #(.DB_CYCLES(1), .CNT_W(4)) dut1 (
        .CLK       (CLK),
        .RST       (RST),
        .btn_n     (btn_n),
        .pulse_out (pulse_out1),
        .pressed   (pressed1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Downstream 4-bit event counter fed by pulse_out, plus a plain pulse tally.
    always @(negedge CLK) begin
        if (pulse_out) begin
            pulse_cnt = pulse_cnt + 1;
            ev_cnt    = ev_cnt + 4'd1;
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One sample of btn_n at the next rising edge; outputs are read 1 time unit later.
    task automatic step(input logic b);
        btn_n = b;
        @(posedge CLK);
        #1;
    endtask

    // Held-low press from IDLE: step index 0 is the first edge sampling btn_n low.
    task automatic run_press(input string tag, input int n, input bit chk1);
        for (int i = 0; i < n; i++) begin
            step(1'b0);
            check($sformatf("%s_pulse[%0d]", tag, i), {7'd0, pulse_out}, {7'd0, (i == 6)});
            check($sformatf("%s_pressed[%0d]", tag, i), {7'd0, pressed}, {7'd0, (i >= 6)});
            if (chk1) begin
                check($sformatf("%s_db1_pulse[%0d]", tag, i), {7'd0, pulse_out1}, {7'd0, (i == 3)});
                check($sformatf("%s_db1_pressed[%0d]", tag, i), {7'd0, pressed1}, {7'd0, (i >= 3)});
            end
        end
    endtask

    // Clean release from HELD: step index 0 is the first edge sampling btn_n high.
    task automatic run_release(input string tag, input int n, input bit chk1);
        for (int j = 0; j < n; j++) begin
            step(1'b1);
            check($sformatf("%s_rel_pulse[%0d]", tag, j), {7'd0, pulse_out}, 8'd0);
            check($sformatf("%s_rel_pressed[%0d]", tag, j), {7'd0, pressed}, {7'd0, (j < 6)});
            if (chk1)
                check($sformatf("%s_db1_rel_pressed[%0d]", tag, j), {7'd0, pressed1}, {7'd0, (j < 3)});
        end
    endtask

    logic bpat [18] = '{0,0,0,1,0,0,0,1,0,0,0,0,0,0,0,0,0,0};
    logic rpat [15] = '{1,1,0,1,1,1,1,1,1,1,1,1,1,1,1};

    initial begin
        int base;
        logic [3:0] ev_base;
        logic [3:0] ev_delta;
        int nb;
        int len;

        RST   = 1'b0;
        btn_n = 1'b1;

        // Reset held with the button toggling: outputs stay low.
        for (int i = 0; i < 5; i++) begin
            step(i[0]);
            check($sformatf("rst_pulse[%0d]", i), {7'd0, pulse_out}, 8'd0);
            check($sformatf("rst_pressed[%0d]", i), {7'd0, pressed}, 8'd0);
            check($sformatf("rst_db1_pulse[%0d]", i), {7'd0, pulse_out1}, 8'd0);
        end
        RST = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1);
        check("idle_pressed", {7'd0, pressed}, 8'd0);

        // Clean press and release, both DB_CYCLES=4 and DB_CYCLES=1.
        base = pulse_cnt;
        run_press("clean", 30, 1'b1);
        run_release("clean", 10, 1'b1);
        check("clean_pulse_count", 8'(pulse_cnt - base), 8'd1);

        // Press bounce: only the final low run qualifies (starts at index 8).
        base = pulse_cnt;
        for (int i = 0; i < 18; i++) begin
            step(bpat[i]);
            check($sformatf("bounce_pulse[%0d]", i), {7'd0, pulse_out}, {7'd0, (i == 14)});
            check($sformatf("bounce_pressed[%0d]", i), {7'd0, pressed}, {7'd0, (i >= 14)});
        end
        // Release bounce: final high run starts at index 3, pressed falls at 9.
        for (int r = 0; r < 15; r++) begin
            step(rpat[r]);
            check($sformatf("relbounce_pulse[%0d]", r), {7'd0, pulse_out}, 8'd0);
            check($sformatf("relbounce_pressed[%0d]", r), {7'd0, pressed}, {7'd0, (r < 9)});
        end
        check("bounce_pulse_count", 8'(pulse_cnt - base), 8'd1);

        // Reset during PRESS_DB, button still held across reset release.
        run_press("rpd", 4, 1'b0);
        RST = 1'b0;
        step(1'b0);
        check("rpd_rst_pulse", {7'd0, pulse_out}, 8'd0);
        check("rpd_rst_pressed", {7'd0, pressed}, 8'd0);
        RST = 1'b1;
        run_press("rpd_after", 10, 1'b0);
        run_release("rpd_after", 8, 1'b0);

        // Reset during the PULSE cycle truncates it; held button re-qualifies.
        run_press("rpl", 7, 1'b0);
        RST = 1'b0;
        step(1'b0);
        check("rpl_rst_pulse", {7'd0, pulse_out}, 8'd0);
        check("rpl_rst_pressed", {7'd0, pressed}, 8'd0);
        RST = 1'b1;
        run_press("rpl_after", 10, 1'b0);
        run_release("rpl_after", 8, 1'b0);

        // Twenty presses with random contact bounce feeding the 4-bit counter.
        base    = pulse_cnt;
        ev_base = ev_cnt;
        for (int p = 0; p < 20; p++) begin
            nb = int'($urandom_range(0, 3));
            for (int b = 0; b < nb; b++) begin
                len = int'($urandom_range(1, 4));
                for (int s = 0; s < len; s++) step(1'b0);
                step(1'b1);
            end
            for (int s = 0; s < 12; s++) step(1'b0);
            nb = int'($urandom_range(0, 3));
            for (int b = 0; b < nb; b++) begin
                len = int'($urandom_range(1, 4));
                for (int s = 0; s < len; s++) step(1'b1);
                step(1'b0);
            end
            for (int s = 0; s < 10; s++) step(1'b1);
        end
        ev_delta = ev_cnt - ev_base;
        check("chain_pulse_count", 8'(pulse_cnt - base), 8'd20);
        check("chain_counter", {4'd0, ev_delta}, 8'b0000_0100);
        check("chain_end_pressed", {7'd0, pressed}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
